// File: rtl/inst_fetch_queue.sv
// ============================================================================
// inst_fetch_queue
//
// Instruction fetch queue that sits between the IF and ID stages. It buffers
// {pc, inst} pairs from fetch, so IF can keep fetching while ID stalls, and it
// presents the oldest entry to decode. A branch/jump redirect from EX flushes
// every queued entry.
//
// Parameters
//   DEPTH  entry count; must be a power of two, >= 2
//   AW     pointer width, derived from DEPTH (do not override)
//
// Ports
//   i_cpu_clk          clock; all state updates on the rising edge
//   i_cpu_rst          synchronous reset, active-high
//   i_flush            redirect from EX; discards all queued entries
//   i_in_valid         fetch offers an entry this cycle
//   o_in_ready         queue accepts an entry (registered count != DEPTH)
//   i_in_pc            fetch PC
//   i_in_inst          fetched instruction word
//   o_out_valid        head entry valid
//   i_out_ready        ID consumes the head this cycle
//   o_out_pc           head PC (0 when empty)
//   o_out_inst         head instruction (LoongArch NOP when empty)
//   o_out_imm_field    o_out_inst[25:0]; drives the sign-extension unit's din
//   o_count            occupied entries, 0..DEPTH
//
// Build option
//   FWFT_BYPASS_EN     when defined, an entry offered to an empty queue is
//                      presented to decode in the same cycle; if decode takes
//                      it right away it is never stored.
// ============================================================================
module inst_fetch_queue #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_cpu_clk,
    input  logic          i_cpu_rst,
    input  logic          i_flush,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [31:0]   i_in_pc,
    input  logic [31:0]   i_in_inst,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [31:0]   o_out_pc,
    output logic [31:0]   o_out_inst,
    output logic [25:0]   o_out_imm_field,
    output logic [AW:0]   o_count
);

    // andi r0,r0,0 -- what decode sees whenever the queue has nothing to offer
    localparam logic [31:0] InstNop   = 32'h0340_0000;
    localparam logic [AW:0] CountFull = (AW+1)'(DEPTH);
    localparam logic [AW:0] CountOne  = (AW+1)'(1);
    localparam logic [AW-1:0] PtrOne  = AW'(1);

    logic [31:0]   r_pc_mem   [DEPTH];
    logic [31:0]   r_inst_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_in_ready;
    logic          w_not_empty;
    logic          w_bypass;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_out_pc;
    logic [31:0]   w_out_inst;

    // Acceptance looks only at the registered count, so a full queue stays
    // closed even if decode pops in the same cycle. This keeps out_ready off
    // the in_ready timing path.
    assign w_in_ready  = (r_count != CountFull);
    assign w_not_empty = (r_count != '0);

`ifdef FWFT_BYPASS_EN
    // Empty queue with a live fetch: show the incoming entry straight away.
    // A redirect in the same cycle suppresses it, since that entry is dead.
    assign w_bypass = ~w_not_empty & i_in_valid & ~i_flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_out_valid = w_not_empty | w_bypass;
    assign w_push      = i_in_valid & w_in_ready;
    assign w_pop       = w_out_valid & i_out_ready;

    // Head selection. A bypassed entry that is popped right away still walks
    // both pointers forward together, so it lands in the slot just being
    // vacated and the count stays at zero without special handling.
    always_comb begin
        w_out_pc   = 32'h0;
        w_out_inst = InstNop;
        if (w_not_empty) begin
            w_out_pc   = r_pc_mem[r_rd_ptr];
            w_out_inst = r_inst_mem[r_rd_ptr];
        end else if (w_bypass) begin
            w_out_pc   = i_in_pc;
            w_out_inst = i_in_inst;
        end
    end

    // Entry storage. It carries no reset: a slot is only ever read after it
    // has been written, and the empty-queue outputs come from the mux above.
    always_ff @(posedge i_cpu_clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= i_in_pc;
            r_inst_mem[r_wr_ptr] <= i_in_inst;
        end
    end

    // Pointer and occupancy bookkeeping. Reset and flush both return the
    // queue to empty, and either one wins over a push or pop in that cycle.
    // The pointers are power-of-two sized, so they wrap on their own.
    always_ff @(posedge i_cpu_clk) begin
        if (i_cpu_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrOne;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CountOne;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CountOne;
            end
        end
    end

    assign o_in_ready      = w_in_ready;
    assign o_out_valid     = w_out_valid;
    assign o_out_pc        = w_out_pc;
    assign o_out_inst      = w_out_inst;
    assign o_out_imm_field = w_out_inst[25:0];
    assign o_count         = r_count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// ============================================================================
// tb_inst_fetch_queue
//
// Self-checking bench for inst_fetch_queue. The driver issues one cycle of
// stimulus at a time, predicts the outputs for that cycle from a plain queue
// model of the fetch buffer, and pushes the prediction into a scoreboard. A
// separate monitor pops the prediction on the falling edge and compares it
// with what the DUT presents. Directed scenarios come first, then a random
// stream of pushes, pops, flushes and resets.
// ============================================================================
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0340_0000;

`ifdef FWFT_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic        valid;
        logic        inReady;
        logic [31:0] pc;
        logic [31:0] inst;
        int          count;
    } expect_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [31:0] inPc;
    logic [31:0] inInst;
    logic        outValid;
    logic        outReady;
    logic [31:0] outPc;
    logic [31:0] outInst;
    logic [25:0] outImm;
    logic [AW:0] count;

    int checks   = 0;
    int failures = 0;

    // Reference model: entries still buffered, oldest first, as {pc, inst}
    logic [63:0] model[$];
    expect_t     scoreboard[$];

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .i_cpu_clk       (clk),
        .i_cpu_rst       (rst),
        .i_flush         (flush),
        .i_in_valid      (inValid),
        .o_in_ready      (inReady),
        .i_in_pc         (inPc),
        .i_in_inst       (inInst),
        .o_out_valid     (outValid),
        .i_out_ready     (outReady),
        .o_out_pc        (outPc),
        .o_out_inst      (outInst),
        .o_out_imm_field (outImm),
        .o_count         (count)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one output field and report it on mismatch
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h",
                     name, $time, actual, expected);
        end
    endtask

    // Drive one cycle: set inputs, predict outputs, let the edge happen, then
    // advance the model by what the queue is supposed to have done.
    task automatic applyStimulus(input logic r, input logic f, input logic v,
                                 input logic rdy, input logic [31:0] pc,
                                 input logic [31:0] inst, input bit chk);
        expect_t e;
        bit      acc;
        bit      take;
        rst      = r;
        flush    = f;
        inValid  = v;
        outReady = rdy;
        inPc     = pc;
        inInst   = inst;

        e.count   = model.size();
        e.inReady = (model.size() != DEPTH);
        if (model.size() != 0) begin
            e.valid = 1'b1;
            e.pc    = model[0][63:32];
            e.inst  = model[0][31:0];
        end else if (BYPASS && v && !f) begin
            e.valid = 1'b1;
            e.pc    = pc;
            e.inst  = inst;
        end else begin
            e.valid = 1'b0;
            e.pc    = 32'h0;
            e.inst  = NOP;
        end
        if (chk) scoreboard.push_back(e);

        acc  = v && e.inReady;
        take = e.valid && rdy;

        @(posedge clk);
        if (r || f) begin
            model.delete();
        end else begin
            if (take && model.size() != 0) begin
                void'(model.pop_front());
                if (acc) model.push_back({pc, inst});
            end else if (acc && !take) begin
                model.push_back({pc, inst});
            end
        end
        #1;
    endtask

    // Monitor: the outputs are checked away from the active edge, against
    // the prediction made when that cycle's stimulus was issued.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (scoreboard.size() != 0) begin
                e = scoreboard.pop_front();
                checkOutput("out_valid", {31'b0, outValid}, {31'b0, e.valid});
                checkOutput("in_ready",  {31'b0, inReady},  {31'b0, e.inReady});
                checkOutput("count",     32'(count),        32'(e.count));
                checkOutput("out_pc",    outPc,             e.pc);
                checkOutput("out_inst",  outInst,           e.inst);
                checkOutput("imm_field", {6'b0, outImm},    {6'b0, e.inst[25:0]});
            end
        end
    end

    initial begin
        logic [31:0] pc;
        int          waitCycles;
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        inPc = 32'h0; inInst = 32'h0;
        @(posedge clk);
        #1;

        // Reset held two cycles; the second cycle already shows reset values
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 0);
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1);

        // Fill with decode stalled, then offer a fifth entry that must bounce
        for (int i = 0; i < 4; i++) begin
            pc = 32'h1C00_0000 + 32'(4 * i);
            applyStimulus(0, 0, 1, 0, pc, $urandom, 1);
        end
        applyStimulus(0, 0, 1, 0, 32'h1C00_0010, $urandom, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1);

        // Drain in order until empty
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 1, 32'h0, 32'h0, 1);
        end

        // Steady stream at two entries: push and pop every cycle
        applyStimulus(0, 0, 1, 0, 32'h1C00_0020, $urandom, 1);
        applyStimulus(0, 0, 1, 0, 32'h1C00_0024, $urandom, 1);
        for (int i = 0; i < 8; i++) begin
            pc = 32'h1C00_0028 + 32'(4 * i);
            applyStimulus(0, 0, 1, 1, pc, $urandom, 1);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, 32'h0, 32'h0, 1);
        end

        // Flush at three entries with a push offered in the same cycle
        for (int i = 0; i < 3; i++) begin
            pc = 32'h1C00_0040 + 32'(4 * i);
            applyStimulus(0, 0, 1, 0, pc, $urandom, 1);
        end
        applyStimulus(0, 1, 1, 1, 32'h1C00_0DEA, $urandom, 1);
        applyStimulus(0, 0, 1, 0, 32'h1C00_0050, $urandom, 1);
        applyStimulus(0, 0, 0, 1, 32'h0, 32'h0, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1);

        // Empty queue with fetch and decode both active
        applyStimulus(0, 0, 1, 1, 32'h1C00_0100, 32'h0280_0421, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1);
        applyStimulus(0, 0, 0, 1, 32'h0, 32'h0, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1);

        // Random traffic with occasional redirects and resets
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 2) != 0),
                          {$urandom} & 32'hFFFF_FFFC, $urandom, 1);
        end
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1);

        // Let the monitor consume anything still pending, within a bound
        waitCycles = 0;
        while (scoreboard.size() != 0 && waitCycles < 10) begin
            @(posedge clk);
            waitCycles++;
        end
        checks++;
        if (scoreboard.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: %0d predictions left, expected 0",
                     scoreboard.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
